// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO and its stream-drain front end.
package fifo_pkg;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int PTR_WIDTH = 4;
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with a registered read port: rdata_o is valid the cycle after rd_en_i.
module fifo #(
  parameter int WIDTH     = fifo_pkg::WIDTH,
  parameter int DEPTH     = fifo_pkg::DEPTH,
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             rd_error_o
);
  localparam logic [PTR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wptr;
  logic [PTR_WIDTH-1:0] r_rptr;
  logic [PTR_WIDTH:0]   r_count;
  logic [WIDTH-1:0]     r_rdata;
  logic                 r_rd_error;
  logic                 w_wr;
  logic                 w_rd;

  assign full_o     = (r_count == (PTR_WIDTH+1)'(DEPTH));
  assign empty_o    = (r_count == '0);
  assign w_wr       = wr_en_i && !full_o;
  assign w_rd       = rd_en_i && !empty_o;
  assign rdata_o    = r_rdata;
  assign rd_error_o = r_rd_error;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rdata    <= '0;
      r_rd_error <= 1'b0;
    end else begin
      r_rd_error <= rd_en_i && empty_o;
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/stream_skid_buf.sv
// Two-entry register buffer: push to tail, pop from head, same-cycle push+pop allowed.
module stream_skid_buf #(
  parameter int WIDTH = fifo_pkg::WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_dat_i,
  input  logic               pop_i,
  output fifo_pkg::occ_t     occ_o,
  output logic [WIDTH-1:0]   head_o,
  output logic               overflow_o
);
  import fifo_pkg::*;

  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  occ_t             r_occ;
  logic [2:0]       w_level;
  logic [2:0]       w_slot;

  assign w_level    = {1'b0, r_occ} + {2'b0, push_i} - {2'b0, pop_i};
  assign w_slot     = {1'b0, r_occ} - {2'b0, pop_i};
  assign overflow_o = push_i && (w_level > 3'(BUF_DEPTH));
  assign occ_o      = r_occ;
  assign head_o     = r_buf0;

  // Pop shifts first; the push then lands in whichever slot is the new tail.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= '0;
    end else begin
      if (pop_i) r_buf0 <= r_buf1;
      if (push_i && w_slot == 3'd0) r_buf0 <= push_dat_i;
      if (push_i && w_slot == 3'd1) r_buf1 <= push_dat_i;
      if (!overflow_o) r_occ <= w_level[1:0];
    end
  end
endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a registered-read FIFO into a framed valid/ready stream at 1 beat/cycle.
module fifo_stream_drain #(
  parameter int WIDTH   = fifo_pkg::WIDTH,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_rd_error_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic             err_o
);
  import fifo_pkg::*;

  localparam logic [7:0]       IDX_LAST = 8'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic             r_inflight;
  logic [7:0]       r_idx;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_err;
  occ_t             w_occ;
  logic [WIDTH-1:0] w_head;
  logic             w_overflow;
  logic             w_pop;
  logic [2:0]       w_level;

  assign m_valid_o  = (w_occ != 2'd0);
  assign w_pop      = m_valid_o && m_ready_i;
  // Slots committed next cycle: buffered + in flight - leaving now.
  assign w_level    = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && (w_level < 3'(BUF_DEPTH));
  assign m_data_o   = w_head;
  assign m_last_o   = m_valid_o && (r_idx == IDX_LAST);
  assign beat_cnt_o = r_beat_cnt;
  assign err_o      = r_err;

  stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (r_inflight),
    .push_dat_i (fifo_rdata_i),
    .pop_i      (w_pop),
    .occ_o      (w_occ),
    .head_o     (w_head),
    .overflow_o (w_overflow)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
      r_idx      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en_o;
      if (w_pop) begin
        r_idx      <= (r_idx == IDX_LAST) ? 8'd0 : r_idx + 8'd1;
        r_beat_cnt <= r_beat_cnt + CNT_ONE;
      end
      if (fifo_rd_error_i || w_overflow) r_err <= 1'b1;
    end
  end
endmodule
